// File: rtl/ctrl_rw_sched.sv
// ctrl_rw_sched: tracks outstanding CAS commands and pulses a per-type
// data-start when each command's CAS-to-data delay expires.
// Latency: start pulse appears in the cycle after edge k+D for a CAS taken at
// edge k. There is no backpressure. A CAS arriving while the table is full is
// dropped and flagged in ovf_err.
//
// Ports:
//   CK_t, reset                  clock, synchronous active-high reset
//   cas_rdy, cas_req, bc4        CAS issue strobe, type, burst-chop flag
//   CL, CWL, AL, RD_PRE, WR_PRE  timing, sampled when a CAS is accepted
//   rd/rda/wr/wra_rdy            one-cycle data-start pulse per CAS type
//   data_idle, rw_done           burst tracker status
//   occ, cas_full                table occupancy
//   ovf_err, coll_err, cfg_err   sticky error flags
module ctrl_rw_sched #(
  parameter int DEPTH = 4,
  parameter int TW    = 5,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic          CK_t,
  input  logic          reset,
  input  logic          cas_rdy,
  input  logic [2:0]    cas_req,
  input  logic          bc4,
  input  logic [TW-1:0] CL,
  input  logic [TW-1:0] CWL,
  input  logic [TW-1:0] AL,
  input  logic [TW-1:0] RD_PRE,
  input  logic [TW-1:0] WR_PRE,
  output logic          rd_rdy,
  output logic          rda_rdy,
  output logic          wr_rdy,
  output logic          wra_rdy,
  output logic          data_idle,
  output logic          rw_done,
  output logic [OW-1:0] occ,
  output logic          cas_full,
  output logic          ovf_err,
  output logic          coll_err,
  output logic          cfg_err
);

  localparam int IW = $clog2(DEPTH);

  // Shared CAS type encoding; every other value is illegal.
  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;

  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);
  localparam logic [TW:0]   TMR_ONE = (TW + 1)'(1);
  localparam logic [2:0]    TRK_BL8 = 3'd4;  // beat-cycles of a BL8 burst
  localparam logic [2:0]    TRK_BC4 = 3'd2;  // beat-cycles of a BC4 burst
  localparam logic [2:0]    TRK_ONE = 3'd1;

  // Entry table
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] bc4_q, bc4_d;
  logic [2:0]       typ_q [DEPTH];
  logic [2:0]       typ_d [DEPTH];
  logic [TW:0]      tmr_q [DEPTH];
  logic [TW:0]      tmr_d [DEPTH];

  logic [OW-1:0] occ_q, occ_d;
  logic [2:0]    trk_q, trk_d;
  logic [3:0]    rdy_q, rdy_d;  // {wra, wr, rda, rd}
  logic          ovf_q, ovf_d;
  logic          coll_q, coll_d;
  logic          cfg_q, cfg_d;

  // Delay computation
  logic               is_rd;
  logic               req_ok;
  logic signed [TW+1:0] dly_s;
  logic               dly_low;
  logic [TW:0]        dly;

  always_comb begin
    is_rd  = (cas_req == RD_R) || (cas_req == RDA_R);
    req_ok = is_rd || (cas_req == WR_R) || (cas_req == WRA_R);
    // Two extra bits: one absorbs the carry of the sum, one carries the sign.
    if (is_rd) begin
      dly_s = $signed({2'b00, CL} + {2'b00, AL} - {2'b00, RD_PRE});
    end else begin
      dly_s = $signed({2'b00, CWL} + {2'b00, AL} - {2'b00, WR_PRE});
    end
    dly_low = dly_s[TW+1] || (dly_s == '0);
    dly     = dly_low ? TMR_ONE : dly_s[TW:0];
  end

  // Expiry, allocation and occupancy
  logic [DEPTH-1:0] expd;
  logic [OW-1:0]    n_exp;
  logic             any_bl8;
  logic             start;
  logic             accept;
  logic [IW-1:0]    free_idx;

  always_comb begin
    vld_d    = vld_q;
    bc4_d    = bc4_q;
    expd     = '0;
    n_exp    = '0;
    any_bl8  = 1'b0;
    rdy_d    = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      typ_d[i] = typ_q[i];
      tmr_d[i] = tmr_q[i];
      expd[i]  = vld_q[i] && (tmr_q[i] == TMR_ONE);
      if (vld_q[i]) begin
        tmr_d[i] = tmr_q[i] - TMR_ONE;
      end
      if (expd[i]) begin
        vld_d[i] = 1'b0;
        n_exp    = n_exp + OCC_ONE;
        if (!bc4_q[i]) begin
          any_bl8 = 1'b1;
        end
        case (typ_q[i])
          RD_R:    rdy_d[0] = 1'b1;
          RDA_R:   rdy_d[1] = 1'b1;
          WR_R:    rdy_d[2] = 1'b1;
          default: rdy_d[3] = 1'b1;
        endcase
      end
    end

    // Scan downward so the lowest free index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_idx = IW'(i);
      end
    end

    // Uses registered occupancy: an entry expiring this edge is not reusable yet.
    accept = cas_rdy && req_ok && (occ_q != DEPTH_C);
    if (accept) begin
      vld_d[free_idx] = 1'b1;
      tmr_d[free_idx] = dly;
      typ_d[free_idx] = cas_req;
      bc4_d[free_idx] = bc4;
    end

    occ_d = occ_q + OW'(accept) - n_exp;
  end

  // Burst tracker and error flags
  always_comb begin
    start = |expd;
    if (start) begin
      trk_d = any_bl8 ? TRK_BL8 : TRK_BC4;
    end else if (trk_q != '0) begin
      trk_d = trk_q - TRK_ONE;
    end else begin
      trk_d = trk_q;
    end
    // remaining==1 is the last beat of the prior burst, so a start then is seamless.
    coll_d = coll_q || (start && (trk_q > TRK_ONE)) || (n_exp > OCC_ONE);
    ovf_d  = ovf_q || (cas_rdy && req_ok && (occ_q == DEPTH_C));
    cfg_d  = cfg_q || (cas_rdy && (!req_ok || dly_low));
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      vld_q  <= '0;
      bc4_q  <= '0;
      occ_q  <= '0;
      trk_q  <= '0;
      rdy_q  <= '0;
      ovf_q  <= 1'b0;
      coll_q <= 1'b0;
      cfg_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        typ_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      bc4_q  <= bc4_d;
      occ_q  <= occ_d;
      trk_q  <= trk_d;
      rdy_q  <= rdy_d;
      ovf_q  <= ovf_d;
      coll_q <= coll_d;
      cfg_q  <= cfg_d;
      for (int i = 0; i < DEPTH; i++) begin
        typ_q[i] <= typ_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign rd_rdy    = rdy_q[0];
  assign rda_rdy   = rdy_q[1];
  assign wr_rdy    = rdy_q[2];
  assign wra_rdy   = rdy_q[3];
  assign data_idle = (trk_q == '0);
  assign rw_done   = (trk_q == TRK_ONE);
  assign occ       = occ_q;
  assign cas_full  = (occ_q == DEPTH_C);
  assign ovf_err   = ovf_q;
  assign coll_err  = coll_q;
  assign cfg_err   = cfg_q;

endmodule

// File: tb/tb_ctrl_rw_sched.sv
// tb_ctrl_rw_sched: directed bench for ctrl_rw_sched (DEPTH=4, TW=5).
// Edge k is the rising edge that samples the inputs driven in loop step k;
// outputs are checked 1 time unit after that edge against per-edge masks.
module tb_ctrl_rw_sched;

  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] BAD_R = 3'd7;

  logic       CK_t = 1'b0;
  logic       reset, cas_rdy, bc4;
  logic [2:0] cas_req;
  logic [4:0] CL, CWL, AL, RD_PRE, WR_PRE;
  logic       rd_rdy, rda_rdy, wr_rdy, wra_rdy, data_idle, rw_done;
  logic [2:0] occ;
  logic       cas_full, ovf_err, coll_err, cfg_err;

  int vectors = 0;
  int miscompares = 0;
  int e = -1;

  // Expected-high masks indexed by edge number; busy_m marks data_idle low.
  logic [63:0] rd_m, rda_m, wr_m, wra_m, busy_m, done_m;

  ctrl_rw_sched #(.DEPTH(4), .TW(5)) dut (
    .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req), .bc4(bc4),
    .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE),
    .rd_rdy(rd_rdy), .rda_rdy(rda_rdy), .wr_rdy(wr_rdy), .wra_rdy(wra_rdy),
    .data_idle(data_idle), .rw_done(rw_done), .occ(occ), .cas_full(cas_full),
    .ovf_err(ovf_err), .coll_err(coll_err), .cfg_err(cfg_err)
  );

  always #5 CK_t = ~CK_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed %0h, expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic clr_masks();
    rd_m = '0; rda_m = '0; wr_m = '0; wra_m = '0; busy_m = '0; done_m = '0;
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
    e++;
    chk("rd_rdy",    32'(rd_rdy),    32'(rd_m[e]));
    chk("rda_rdy",   32'(rda_rdy),   32'(rda_m[e]));
    chk("wr_rdy",    32'(wr_rdy),    32'(wr_m[e]));
    chk("wra_rdy",   32'(wra_rdy),   32'(wra_m[e]));
    chk("data_idle", 32'(data_idle), 32'(!busy_m[e]));
    chk("rw_done",   32'(rw_done),   32'(done_m[e]));
  endtask

  task automatic do_reset();
    reset = 1'b1; cas_rdy = 1'b1; cas_req = RD_R; bc4 = 1'b0;
    CL = 5'd11; CWL = 5'd9; AL = 5'd0; RD_PRE = 5'd1; WR_PRE = 5'd1;
    @(posedge CK_t);
    #1;
    reset = 1'b0; cas_rdy = 1'b0;
    chk("rst_rd_rdy",   32'(rd_rdy),    32'd0);
    chk("rst_rda_rdy",  32'(rda_rdy),   32'd0);
    chk("rst_wr_rdy",   32'(wr_rdy),    32'd0);
    chk("rst_wra_rdy",  32'(wra_rdy),   32'd0);
    chk("rst_rw_done",  32'(rw_done),   32'd0);
    chk("rst_idle",     32'(data_idle), 32'd1);
    chk("rst_cas_full", 32'(cas_full),  32'd0);
    chk("rst_occ",      32'(occ),       32'd0);
    chk("rst_errs",     32'({ovf_err, coll_err, cfg_err}), 32'd0);
    e = -1;
    clr_masks();
  endtask

  initial begin
    clr_masks();

    // Single RD, D=10, BL8
    do_reset();
    rd_m[10] = 1'b1; busy_m[13:10] = 4'hF; done_m[13] = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cas_rdy = (k == 0); cas_req = RD_R;
      tick();
      if (k == 0 || k == 9) chk("s1_occ1", 32'(occ), 32'd1);
      if (k == 10) chk("s1_occ0", 32'(occ), 32'd0);
    end

    // WR (D=8) at edge 0, RD (D=10) at edge 4
    do_reset();
    wr_m[8] = 1'b1; rd_m[14] = 1'b1;
    busy_m[11:8] = 4'hF; busy_m[17:14] = 4'hF; done_m[11] = 1'b1; done_m[17] = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      cas_rdy = (k == 0 || k == 4); cas_req = (k == 0) ? WR_R : RD_R;
      tick();
      if (k == 4) chk("s2_occ_peak", 32'(occ), 32'd2);
      if (k == 8) chk("s2_occ_after_wr", 32'(occ), 32'd1);
    end
    chk("s2_errs", 32'({ovf_err, coll_err, cfg_err}), 32'd0);

    // Overflow: five RDs with D=12 on edges 0..4
    do_reset();
    CL = 5'd13;
    rd_m[15:12] = 4'hF; busy_m[18:12] = 7'h7F; done_m[18] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      cas_rdy = (k <= 4); cas_req = RD_R;
      tick();
      if (k == 2) chk("s3_full_k2", 32'({cas_full, occ}), 32'h3);
      if (k == 3) chk("s3_full_k3", 32'({cas_full, occ}), 32'hC);
      if (k == 3) chk("s3_ovf_k3", 32'(ovf_err), 32'd0);
      if (k == 4) chk("s3_ovf_k4", 32'(ovf_err), 32'd1);
      if (k == 15) chk("s3_occ_end", 32'(occ), 32'd0);
    end
    chk("s3_coll", 32'(coll_err), 32'd1);

    // Collision: RD D=10 at edge 0, RD D=8 at edge 4
    do_reset();
    rd_m[10] = 1'b1; rd_m[12] = 1'b1; busy_m[15:10] = 6'h3F; done_m[15] = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      cas_rdy = (k == 0 || k == 4); cas_req = RD_R;
      CL = (k == 4) ? 5'd9 : 5'd11;
      tick();
      if (k == 11) chk("s4_coll_k11", 32'(coll_err), 32'd0);
      if (k == 12) chk("s4_coll_k12", 32'(coll_err), 32'd1);
    end

    // BC4 back-to-back: RDs D=10 at edges 0 and 2
    do_reset();
    rd_m[10] = 1'b1; rd_m[12] = 1'b1; busy_m[13:10] = 4'hF;
    done_m[11] = 1'b1; done_m[13] = 1'b1;
    bc4 = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cas_rdy = (k == 0 || k == 2); cas_req = RD_R;
      tick();
    end
    bc4 = 1'b0;
    chk("s5_coll", 32'(coll_err), 32'd0);

    // Reset mid-flight with three pending RDs and a cfg_err, then a fresh RD at edge 7
    do_reset();
    rd_m[17] = 1'b1; busy_m[20:17] = 4'hF; done_m[20] = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      reset = (k == 5);
      cas_rdy = (k <= 3) || (k == 5) || (k == 7);
      cas_req = (k == 3) ? BAD_R : RD_R;
      tick();
      if (k == 3) chk("s6_cfg_set", 32'({cfg_err, occ}), 32'hB);
      if (k == 5) chk("s6_rst_occ", 32'(occ), 32'd0);
      if (k == 5) chk("s6_rst_errs", 32'({ovf_err, coll_err, cfg_err}), 32'd0);
      if (k == 7) chk("s6_occ_new", 32'(occ), 32'd1);
    end
    reset = 1'b0;

    // Negative delay clamps to 1 and flags cfg_err (RDA path)
    do_reset();
    CL = 5'd0; AL = 5'd0; RD_PRE = 5'd3;
    rda_m[1] = 1'b1; busy_m[4:1] = 4'hF; done_m[4] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      cas_rdy = (k == 0); cas_req = RDA_R;
      tick();
      if (k == 0) chk("s7_cfg", 32'(cfg_err), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
